// File: rtl/bfp_scale_ctrl_pkg.sv
// Shared FSM state encoding and default scaling target for the BFP scale controller.
package bfp_scale_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int TARGET_IDX_DEF = 15;

endpackage

// File: rtl/bfp_scale_ctrl_mag_detect.sv
// Leading-sign detector: index of the highest bit that differs from the sign bit.
// Combinational; zero and -1 both map to index 0.
module mag_detect_v2 #(
  parameter int WIDTH = 23,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (data_i[i] != data_i[WIDTH-1]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bfp_scale_ctrl.sv
// Per-frame max leading-sign tracker producing a right-shift for the next FFT stage; report 2 cycles
// after the last accept, in_ready low until the report is taken. BFP_EXP_ACC_EN enables blk_exp accumulation.
module bfp_scale_ctrl
  import bfp_scale_ctrl_pkg::*;
#(
  parameter int WIDTH      = 23,
  parameter int FRAME_LEN  = 512,
  parameter int TARGET_IDX = TARGET_IDX_DEF,
  parameter int EXP_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     scale_valid,
  input  logic                     scale_ready,
  output logic [$clog2(WIDTH)-1:0] scale_shift,
  output logic [$clog2(WIDTH)-1:0] max_idx,
  output logic [EXP_W-1:0]         blk_exp
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] TGT  = IDX_W'(TARGET_IDX);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] max_q, max_d, max_nxt;
  logic             pipe_vld_q, pipe_vld_d;
  logic [IDX_W-1:0] pipe_idx_q, pipe_idx_d;
  logic [IDX_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] maxo_q, maxo_d;
  logic [IDX_W-1:0] det_idx;
  logic             accept, hs;

  mag_detect_v2 #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_mag (
    .data_i (in_data),
    .idx_o  (det_idx)
  );

  assign in_ready    = (state_q == IDLE) || (state_q == ACCUM);
  assign scale_valid = (state_q == REPORT);
  assign accept      = in_valid && in_ready;
  assign hs          = scale_valid && scale_ready;
  assign scale_shift = shift_q;
  assign max_idx     = maxo_q;

  // Max including the index still in the pipe, so DRAIN sees the last sample.
  assign max_nxt = (pipe_vld_q && (pipe_idx_q > max_q)) ? pipe_idx_q : max_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    max_d      = max_nxt;
    pipe_vld_d = accept;
    pipe_idx_d = accept ? det_idx : pipe_idx_q;
    shift_d    = shift_q;
    maxo_d     = maxo_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCUM;
          max_d   = '0;
        end
      end
      ACCUM:  if (accept && (cnt_q == LAST)) state_d = DRAIN;
      DRAIN: begin
        state_d = REPORT;
        maxo_d  = max_nxt;
        shift_d = (max_nxt > TGT) ? (max_nxt - TGT) : '0;
      end
      REPORT: if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

    if (frame_clr) begin
      state_d    = IDLE;
      cnt_d      = '0;
      max_d      = '0;
      pipe_vld_d = 1'b0;
      shift_d    = shift_q;
      maxo_d     = maxo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      max_q      <= '0;
      pipe_vld_q <= 1'b0;
      pipe_idx_q <= '0;
      shift_q    <= '0;
      maxo_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_idx_q <= pipe_idx_d;
      shift_q    <= shift_d;
      maxo_q     <= maxo_d;
    end
  end

`ifdef BFP_EXP_ACC_EN
  logic [EXP_W-1:0] exp_q;
  logic [EXP_W:0]   exp_sum;

  assign exp_sum = {1'b0, exp_q} + (EXP_W + 1)'(shift_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
    end else if (hs && !frame_clr) begin
      exp_q <= exp_sum[EXP_W] ? '1 : exp_sum[EXP_W-1:0];
    end
  end

  assign blk_exp = exp_q;
`else
  assign blk_exp = '0;
`endif

endmodule

// File: doc/bfp_scale_ctrl.md
BFP_SCALE_CTRL -- requirements
Module: bfp_scale_ctrl

Interface
REQ-001 Parameter WIDTH, default 23: signed sample width fed to the leading-sign detector.
REQ-002 Parameter FRAME_LEN, default 512: accepted samples per FFT stage frame; power of two, at least 2.
REQ-003 Parameter TARGET_IDX, default 15: highest permitted MSB index after scaling; valid range 0..WIDTH-2.
REQ-004 Parameter EXP_W, default 8: width of the block-exponent accumulator.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port frame_clr, input, 1: synchronous abort of the current frame.
REQ-008 Port in_valid, input, 1: sample qualifier.
REQ-009 Port in_ready, output, 1: block accepts a sample this cycle.
REQ-010 Port in_data, input, WIDTH: signed stage-output sample.
REQ-011 Port scale_valid, output, 1: scale result available.
REQ-012 Port scale_ready, input, 1: consumer accepts the scale result.
REQ-013 Port scale_shift, output, $clog2(WIDTH): right-shift amount for the next stage.
REQ-014 Port max_idx, output, $clog2(WIDTH): largest MSB index seen in the frame.
REQ-015 Port blk_exp, output, EXP_W: cumulative block exponent.

Function
REQ-016 Accept a sample only when in_valid and in_ready are both high.
REQ-017 Feed every accepted sample to the leading-sign index function; its result is registered one cycle later (1-cycle pipe).
REQ-018 FSM states and transitions: IDLE -> ACCUM on first accept; ACCUM -> DRAIN on accept with count==FRAME_LEN-1; DRAIN -> REPORT after exactly 1 cycle; REPORT -> IDLE on scale_valid && scale_ready.
REQ-019 in_ready = 1 in IDLE and ACCUM; 0 in DRAIN and REPORT. in_valid is ignored and not counted while in_ready is low.
REQ-020 Frame counter: log2(FRAME_LEN) bits, increments per accept, wraps to 0 after the last sample.
REQ-021 Running max updates from each registered index using unsigned compare; it clears to 0 when entering ACCUM from IDLE.
REQ-022 scale_shift = max > TARGET_IDX ? max - TARGET_IDX : 0. Computed in DRAIN and held constant throughout REPORT.
REQ-023 scale_valid = 1 only in REPORT; scale_shift and max_idx stay stable until the handshake completes.
REQ-024 If frame_clr is high in any state, the FSM goes to IDLE and the counter, running max and pipe valid are cleared; scale_valid is low the next cycle. frame_clr has priority over a simultaneous accept or handshake.
REQ-025 When frame_clr is high, blk_exp is not cleared.
REQ-026 Zero and -1 samples contribute index 0.

Reset
REQ-027 On rst_n low, all state clears asynchronously: FSM=IDLE, counter=0, running max=0, pipe valid=0, scale_shift=0, max_idx=0, blk_exp=0, scale_valid=0.
REQ-028 in_ready is 1 from the first cycle after reset release.
REQ-029 Reset asserted in any state, including mid-frame or mid-REPORT, discards the frame with no partial result.

Configuration
REQ-030 Macro BFP_EXP_ACC_EN defined: on each REPORT handshake, blk_exp += scale_shift, saturating at 2^EXP_W-1.
REQ-031 Macro BFP_EXP_ACC_EN undefined: blk_exp is tied to 0, the accumulator logic is absent, and the port is still present.

Structure
REQ-032 A shared package holds the FSM state enum (IDLE, ACCUM, DRAIN, REPORT) and the default TARGET_IDX constant.
REQ-033 Exactly one sub-module: the existing leading-sign detector mag_detect_v2, instantiated with WIDTH; no other hierarchy.

Verification (WIDTH=23, FRAME_LEN=8, TARGET_IDX=15)
REQ-034 Eight zero samples -> scale_valid 2 cycles after the 8th accept, max_idx=0, scale_shift=0.
REQ-035 Frame containing 0x100000 (idx 20) plus small values, then in_data 0x400000 (idx 21) in the next frame -> shifts 5 and 6, respectively.
REQ-036 scale_ready held low 5 cycles in REPORT, in_valid high -> scale_valid, scale_shift and in_ready=0 all steady; no samples counted; the frame after the handshake counts from 0.
REQ-037 frame_clr after 3 accepts, then 8 samples including idx 18 -> single report with scale_shift=3; no report from the aborted samples.
REQ-038 rst_n pulsed low during REPORT -> scale_valid=0 immediately, in_ready=1 after release, blk_exp=0.
REQ-039 With BFP_EXP_ACC_EN defined, two frames with shifts 5 and 3 -> blk_exp=8; without the macro -> blk_exp=0.
